// File: rtl/hlsm_operand_loader_pkg.sv
// Shared definitions for the HLSM operand loader and its 34-operand accumulator.
// Optional feature macro: HLSM_LOADER_TIMEOUT_EN (WAIT-state timeout).
package hlsm_pkg;

    localparam int DATA_W       = 33;
    localparam int NUM_OPS      = 34;
    localparam int HLSM_LATENCY = 36;
    localparam int TIMEOUT_CYC  = 64;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        KICK   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/hlsm_operand_loader_if.sv
// Bundle of the operand stream, accumulator link and result port of the loader.
// The master modport is the loader's view; slave is the surrounding environment.
interface hlsm_operand_loader_if #(
    parameter int DATA_W  = hlsm_pkg::DATA_W,
    parameter int NUM_OPS = hlsm_pkg::NUM_OPS
);

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      in_last;
    logic [NUM_OPS*DATA_W-1:0] ops;
    logic                      Start;
    logic                      Done;
    logic [DATA_W-1:0]         final_in;
    logic                      res_valid;
    logic [DATA_W-1:0]         res_data;
    logic                      res_ready;
    logic                      err;

    modport master (
        input  in_valid, in_data, in_last, Done, final_in, res_ready,
        output in_ready, ops, Start, res_valid, res_data, err
    );

    modport slave (
        output in_valid, in_data, in_last, Done, final_in, res_ready,
        input  in_ready, ops, Start, res_valid, res_data, err
    );

endinterface

// File: rtl/hlsm_operand_loader.sv
// Operand loader for the HLSM accumulator: fills a register bank from a
// valid/ready stream, kicks the accumulator, waits for Done and offers the
// result on a valid/ready port. Framing errors set a sticky err flag.
// Optional feature macro: HLSM_LOADER_TIMEOUT_EN adds a WAIT timeout.
module hlsm_operand_loader #(
    parameter int DATA_W  = hlsm_pkg::DATA_W,
    parameter int NUM_OPS = hlsm_pkg::NUM_OPS
`ifdef HLSM_LOADER_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = hlsm_pkg::TIMEOUT_CYC
`endif
) (
    input  logic                   Clk,
    input  logic                   Rst,
    hlsm_operand_loader_if.master  bus
);

    import hlsm_pkg::*;

    localparam int              CNT_W    = $clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

    loader_state_t     r_state;
    loader_state_t     w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_bank [NUM_OPS];
    logic [DATA_W-1:0] r_resData;
    logic              r_err;

    logic              w_beat;
    logic              w_lastBeat;
    logic              w_earlyLast;
    logic              w_timeout;

    assign w_beat      = bus.in_valid && (r_state == LOAD);
    assign w_lastBeat  = w_beat && (r_cnt == LAST_IDX);
    assign w_earlyLast = w_beat && (r_cnt != LAST_IDX) && bus.in_last;

`ifdef HLSM_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_waitCnt;

    assign w_timeout = (r_state == WAIT) && !bus.Done &&
                       (r_waitCnt == TO_W'(TIMEOUT_CYC - 1));

    // Count cycles spent in WAIT, restarting from zero on every entry.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_waitCnt <= '0;
        end else if (r_state == KICK) begin
            r_waitCnt <= '0;
        end else if (r_state == WAIT) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and state-decoded handshake/start outputs.
    always_comb begin
        w_nextState   = r_state;
        bus.in_ready  = 1'b0;
        bus.Start     = 1'b0;
        bus.res_valid = 1'b0;
        case (r_state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (w_lastBeat) begin
                    w_nextState = KICK;
                end
            end
            KICK: begin
                bus.Start   = 1'b1;
                w_nextState = WAIT;
            end
            WAIT: begin
                if (bus.Done) begin
                    w_nextState = RESULT;
                end else if (w_timeout) begin
                    w_nextState = LOAD;
                end
            end
            RESULT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_nextState = LOAD;
                end
            end
            default: w_nextState = LOAD;
        endcase
    end

    // Operand bank, beat counter, captured result and sticky error flag.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_cnt     <= '0;
            r_resData <= '0;
            r_err     <= 1'b0;
            for (int k = 0; k < NUM_OPS; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            if (w_beat) begin
                r_bank[r_cnt] <= bus.in_data;
                r_cnt         <= w_earlyLast ? '0 : r_cnt + 1'b1;
            end
            if ((w_lastBeat && !bus.in_last) || w_earlyLast || w_timeout) begin
                r_err <= 1'b1;
            end
            if ((r_state == WAIT) && bus.Done) begin
                r_resData <= bus.final_in;
            end
            if (((r_state == RESULT) && bus.res_ready) || w_timeout) begin
                r_cnt <= '0;
            end
        end
    end

    // Flatten the bank onto the accumulator's parallel operand bus.
    always_comb begin
        bus.ops = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            bus.ops[k*DATA_W +: DATA_W] = r_bank[k];
        end
    end

    assign bus.res_data = r_resData;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_hlsm_operand_loader.sv
// Testbench for hlsm_operand_loader: random operand jobs through a
// behavioural 36-cycle accumulator, with framing errors, backpressure,
// reset mid-job, stray Done and (with HLSM_LOADER_TIMEOUT_EN) timeout.
module tb_hlsm_operand_loader;

    import hlsm_pkg::*;

    localparam int DW   = DATA_W;
    localparam int NOPS = NUM_OPS;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    hlsm_operand_loader_if bus ();

    hlsm_operand_loader dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 Clk = ~Clk;

    int checkCount = 0;
    int failCount  = 0;

    logic          accEnable  = 1'b1;
    logic          accBusy    = 1'b0;
    int            accLeft    = 0;
    logic          accDone    = 1'b0;
    logic [DW-1:0] accFinal   = '0;
    logic          forceDone  = 1'b0;
    logic [DW-1:0] forceFinal = '0;

    assign bus.Done     = accDone | forceDone;
    assign bus.final_in = forceDone ? forceFinal : accFinal;

    logic [DW-1:0] tbOps [NOPS];
    logic [DW-1:0] tbExpRes;
    logic          tbErr;

    // Accumulator behaviour: result is the sum of all operands plus the first.
    function automatic logic [DW-1:0] accResult(input logic [NOPS*DW-1:0] v);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < NOPS; k++) begin
            s = s + v[k*DW +: DW];
        end
        return s + v[DW-1:0];
    endfunction

    // Accumulator model: Done rises HLSM_LATENCY edges after Start is sampled.
    always @(posedge Clk) begin
        if (!Rst) begin
            accBusy <= 1'b0;
            accDone <= 1'b0;
            accLeft <= 0;
        end else if (accBusy) begin
            if (accLeft == 1) begin
                accDone  <= 1'b1;
                accFinal <= accResult(bus.ops);
                accLeft  <= 0;
            end else if (accLeft == 0) begin
                accDone <= 1'b0;
                accBusy <= 1'b0;
            end else begin
                accLeft <= accLeft - 1;
            end
        end else if (bus.Start && accEnable) begin
            accBusy <= 1'b1;
            accLeft <= HLSM_LATENCY - 1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input bit last);
        if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        checkOutput("in_ready_load", bus.in_ready, 1);
        tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"},  bus.in_ready,  1);
        checkOutput({tag, "_start"},     bus.Start,     0);
        checkOutput({tag, "_res_valid"}, bus.res_valid, 0);
        checkOutput({tag, "_res_data"},  bus.res_data,  0);
        checkOutput({tag, "_err"},       bus.err,       0);
        checkOutput({tag, "_ops_zero"},  bus.ops == '0, 1);
    endtask

    task automatic streamJob(input bit useRandom, input bit dropLast);
        logic [NOPS*DW-1:0] expOps;
        logic [DW-1:0]      sum;
        sum = '0;
        for (int i = 0; i < NOPS; i++) begin
            tbOps[i] = useRandom ? DW'({$urandom, $urandom}) : DW'(i + 1);
            sum      = sum + tbOps[i];
            expOps[i*DW +: DW] = tbOps[i];
        end
        tbExpRes = sum + tbOps[0];
        for (int i = 0; i < NOPS; i++) begin
            applyStimulus(tbOps[i], (i == NOPS - 1) && !dropLast);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (dropLast) tbErr = 1'b1;
        checkOutput("start_pulse", bus.Start, 1);
        checkOutput("ops_bank", bus.ops == expOps, 1);
        checkOutput("in_ready_kick", bus.in_ready, 0);
    endtask

    task automatic finishJob(input int holdCycles);
        int waited;
        int starts;
        logic [DW-1:0] heldData;
        tick();
        checkOutput("start_once", bus.Start, 0);
        checkOutput("in_ready_wait", bus.in_ready, 0);
        waited = 0;
        starts = 0;
        while (!bus.res_valid && waited < 200) begin
            tick();
            waited++;
            starts += int'(bus.Start);
        end
        checkOutput("done_latency", waited, HLSM_LATENCY);
        checkOutput("extra_start", starts, 0);
        checkOutput("res_data", bus.res_data, tbExpRes);
        checkOutput("err_flag", bus.err, tbErr);
        heldData = bus.res_data;
        for (int c = 0; c < holdCycles; c++) begin
            tick();
            checkOutput("hold_valid", bus.res_valid, 1);
            checkOutput("hold_data", bus.res_data, heldData);
            checkOutput("hold_in_ready", bus.in_ready, 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checkOutput("ready_after_res", bus.in_ready, 1);
        checkOutput("res_valid_clear", bus.res_valid, 0);
    endtask

    task automatic abortJob(input int beats);
        for (int i = 0; i < beats; i++) begin
            applyStimulus(DW'({$urandom, $urandom}), i == beats - 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tbErr = 1'b1;
        checkOutput("abort_err", bus.err, 1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("abort_no_start", bus.Start, 0);
            checkOutput("abort_in_ready", bus.in_ready, 1);
            tick();
        end
    endtask

    initial begin
        logic [DW-1:0] prevRes;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;
        tbErr         = 1'b0;

        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        checkResetOutputs("reset");

        streamJob(1'b0, 1'b0);
        checkOutput("seq_expected_596", tbExpRes, 596);
        finishJob(10);

        streamJob(1'b1, 1'b0);
        finishJob($urandom_range(0, 5));
        streamJob(1'b1, 1'b0);
        finishJob($urandom_range(0, 5));

        prevRes    = bus.res_data;
        forceFinal = DW'({$urandom, $urandom});
        forceDone  = 1'b1;
        tick();
        forceDone  = 1'b0;
        checkOutput("stray_done_valid", bus.res_valid, 0);
        checkOutput("stray_done_ready", bus.in_ready, 1);
        checkOutput("stray_done_data", bus.res_data, prevRes);
        tick();
        checkOutput("stray_done_valid2", bus.res_valid, 0);

        streamJob(1'b1, 1'b1);
        finishJob(1);

        abortJob(5);
        streamJob(1'b1, 1'b0);
        finishJob(2);

        streamJob(1'b1, 1'b0);
        repeat (10) tick();
        Rst = 1'b0;
        tick();
        checkResetOutputs("wait_reset");
        Rst   = 1'b1;
        tbErr = 1'b0;
        tick();
        streamJob(1'b1, 1'b0);
        finishJob(0);

`ifdef HLSM_LOADER_TIMEOUT_EN
        begin
            int waited;
            int sawValid;
            accEnable = 1'b0;
            streamJob(1'b1, 1'b0);
            tick();
            waited   = 0;
            sawValid = 0;
            while (!bus.err && waited < TIMEOUT_CYC + 20) begin
                tick();
                waited++;
                sawValid += int'(bus.res_valid);
            end
            tbErr = 1'b1;
            checkOutput("timeout_cycles", waited, TIMEOUT_CYC);
            checkOutput("timeout_no_valid", sawValid, 0);
            checkOutput("timeout_in_ready", bus.in_ready, 1);
            accEnable = 1'b1;
            streamJob(1'b1, 1'b0);
            finishJob(0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
